// File: rtl/out_mem_acc_ctrl.sv
// Output-memory sequencer: pipelined per-lane read-modify-write accumulation with
// hazard forwarding, plus a backpressured drain sweep with optional row clearing.
module out_mem_acc_ctrl #(
  parameter int NUM_BANK   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           acc_valid,
  output logic                           acc_ready,
  input  logic [ADDR_WIDTH-1:0]          acc_addr,
  input  logic [NUM_BANK-1:0]            acc_mask,
  input  logic                           acc_init,
  input  logic [NUM_BANK*DATA_WIDTH-1:0] acc_data,
  input  logic                           drain_start,
  input  logic [ADDR_WIDTH-1:0]          drain_base,
  input  logic [ADDR_WIDTH:0]            drain_len,
  input  logic                           drain_clear,
  output logic                           drain_busy,
  output logic                           drain_valid,
  input  logic                           drain_ready,
  output logic [ADDR_WIDTH-1:0]          drain_addr,
  output logic [NUM_BANK*DATA_WIDTH-1:0] drain_data,
  output logic                           drain_done,
  output logic [NUM_BANK-1:0]            mem_rd_en,
  output logic [NUM_BANK*ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [NUM_BANK*DATA_WIDTH-1:0] mem_rd_data,
  output logic [NUM_BANK-1:0]            mem_wr_en,
  output logic [NUM_BANK*ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [NUM_BANK*DATA_WIDTH-1:0] mem_wr_data
);
  localparam int NW = NUM_BANK * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, DONE} state_t;
  state_t state_q;

  logic                  e_vld_q, w_vld_q, w2_vld_q;
  logic                  e_init_q;
  logic [ADDR_WIDTH-1:0] e_addr_q, w_addr_q, w2_addr_q;
  logic [NUM_BANK-1:0]   e_mask_q, w_mask_q, w2_mask_q;
  logic [NW-1:0]         e_data_q, w_sum_q, w2_sum_q, sum_d;
  logic [DATA_WIDTH-1:0] opnd [NUM_BANK];

  logic [ADDR_WIDTH-1:0] rd_addr_q, infl_addr_q;
  logic [ADDR_WIDTH:0]   len_q, iss_q, hs_q;
  logic                  clr_q, infl_q;
  logic [1:0]            sk_cnt_q;
  logic [NW-1:0]         sk_data_q [2];
  logic [NW-1:0]         sk_data_d [2];
  logic [ADDR_WIDTH-1:0] sk_addr_q [2];
  logic [ADDR_WIDTH-1:0] sk_addr_d [2];

  logic acc_fire, issue, pop, last, clr_wr, sk_slot;
  logic [ADDR_WIDTH-1:0] rd_addr_sel, wr_addr_sel;

  assign acc_ready = (state_q == IDLE) & ~drain_start;
  assign acc_fire  = acc_valid & acc_ready;
  assign issue     = (state_q == DRAIN) && (iss_q != len_q) &&
                     ((sk_cnt_q + {1'b0, infl_q}) < 2'd2);
  assign pop       = (sk_cnt_q != 2'd0) & drain_ready;
  assign last      = pop && (hs_q == len_q - (ADDR_WIDTH+1)'(1));
  assign clr_wr    = infl_q & clr_q;
  // After a pop the incoming row lands in the first free slot of the shifted buffer
  assign sk_slot   = pop ? (sk_cnt_q == 2'd2) : (sk_cnt_q == 2'd1);

  // E stage: pick the freshest copy of each lane's operand, youngest write first
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      if (e_init_q)
        opnd[i] = '0;
      else if (w_vld_q && (w_addr_q == e_addr_q) && w_mask_q[i])
        opnd[i] = w_sum_q[i*DATA_WIDTH +: DATA_WIDTH];
      else if (w2_vld_q && (w2_addr_q == e_addr_q) && w2_mask_q[i])
        opnd[i] = w2_sum_q[i*DATA_WIDTH +: DATA_WIDTH];
      else
        opnd[i] = mem_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      sum_d[i*DATA_WIDTH +: DATA_WIDTH] = opnd[i] + e_data_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    sk_data_d = sk_data_q;
    sk_addr_d = sk_addr_q;
    if (pop) begin
      sk_data_d[0] = sk_data_q[1];
      sk_addr_d[0] = sk_addr_q[1];
    end
    if (infl_q) begin
      sk_data_d[sk_slot] = mem_rd_data;
      sk_addr_d[sk_slot] = infl_addr_q;
    end
  end

  // Control state: FSM, stage valids and drain counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      e_vld_q   <= 1'b0;
      w_vld_q   <= 1'b0;
      w2_vld_q  <= 1'b0;
      infl_q    <= 1'b0;
      sk_cnt_q  <= 2'd0;
      rd_addr_q <= '0;
      len_q     <= '0;
      iss_q     <= '0;
      hs_q      <= '0;
      clr_q     <= 1'b0;
    end else begin
      e_vld_q  <= acc_fire;
      w_vld_q  <= e_vld_q;
      w2_vld_q <= w_vld_q;
      infl_q   <= issue;
      sk_cnt_q <= sk_cnt_q - {1'b0, pop} + {1'b0, infl_q};
      if (issue) begin
        rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
        iss_q     <= iss_q + (ADDR_WIDTH+1)'(1);
      end
      if (pop) hs_q <= hs_q + (ADDR_WIDTH+1)'(1);
      case (state_q)
        IDLE: if (drain_start) begin
          state_q   <= FLUSH;
          rd_addr_q <= drain_base;
          len_q     <= drain_len;
          clr_q     <= drain_clear;
          iss_q     <= '0;
          hs_q      <= '0;
        end
        FLUSH: if (!e_vld_q && !w_vld_q) state_q <= (len_q == '0) ? DONE : DRAIN;
        DRAIN: if (last) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers, qualified everywhere by the control valids above
  always_ff @(posedge clk) begin
    e_addr_q    <= acc_addr;
    e_mask_q    <= acc_mask;
    e_init_q    <= acc_init;
    e_data_q    <= acc_data;
    w_addr_q    <= e_addr_q;
    w_mask_q    <= e_mask_q;
    w_sum_q     <= sum_d;
    w2_addr_q   <= w_addr_q;
    w2_mask_q   <= w_mask_q;
    w2_sum_q    <= w_sum_q;
    infl_addr_q <= rd_addr_q;
    sk_data_q   <= sk_data_d;
    sk_addr_q   <= sk_addr_d;
  end

  assign rd_addr_sel = acc_fire ? acc_addr : (issue ? rd_addr_q : '0);
  assign wr_addr_sel = w_vld_q ? w_addr_q : (clr_wr ? infl_addr_q : '0);

  assign mem_rd_en   = acc_fire ? acc_mask : (issue ? '1 : '0);
  assign mem_rd_addr = {NUM_BANK{rd_addr_sel}};
  assign mem_wr_en   = w_vld_q ? w_mask_q : (clr_wr ? '1 : '0);
  assign mem_wr_addr = {NUM_BANK{wr_addr_sel}};
  assign mem_wr_data = w_vld_q ? w_sum_q : '0;

  assign drain_valid = (sk_cnt_q != 2'd0);
  assign drain_addr  = drain_valid ? sk_addr_q[0] : '0;
  assign drain_data  = drain_valid ? sk_data_q[0] : '0;
  assign drain_busy  = (state_q == FLUSH) || (state_q == DRAIN);
  assign drain_done  = (state_q == DONE);
endmodule

// File: tb/tb_out_mem_acc_ctrl.sv
// Randomized bench for out_mem_acc_ctrl: a behavioural banked RAM and a
// sequential row/lane reference model that every drained row is compared against.
module tb_out_mem_acc_ctrl;
  localparam int NB = 16;
  localparam int DW = 32;
  localparam int AW = 8;

  logic              clk, rst;
  logic              acc_valid, acc_ready, acc_init;
  logic [AW-1:0]     acc_addr;
  logic [NB-1:0]     acc_mask;
  logic [NB*DW-1:0]  acc_data;
  logic              drain_start, drain_clear, drain_busy, drain_valid, drain_ready, drain_done;
  logic [AW-1:0]     drain_base, drain_addr;
  logic [AW:0]       drain_len;
  logic [NB*DW-1:0]  drain_data;
  logic [NB-1:0]     mem_rd_en, mem_wr_en;
  logic [NB*AW-1:0]  mem_rd_addr, mem_wr_addr;
  logic [NB*DW-1:0]  mem_rd_data = '0;
  logic [NB*DW-1:0]  mem_wr_data;

  logic [DW-1:0] ram [NB][256] = '{default: '0};
  logic [DW-1:0] ref_mem [256][NB];
  int checks = 0;
  int errors = 0;

  out_mem_acc_ctrl #(.NUM_BANK(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_addr(acc_addr),
    .acc_mask(acc_mask), .acc_init(acc_init), .acc_data(acc_data),
    .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
    .drain_clear(drain_clear), .drain_busy(drain_busy), .drain_valid(drain_valid),
    .drain_ready(drain_ready), .drain_addr(drain_addr), .drain_data(drain_data),
    .drain_done(drain_done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Banked RAM; a same-row read/write collision returns poison.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_rd_en[b]) begin
        if (mem_wr_en[b] && mem_wr_addr[b*AW +: AW] == mem_rd_addr[b*AW +: AW])
          mem_rd_data[b*DW +: DW] <= 32'hDEAD_BEEF;
        else
          mem_rd_data[b*DW +: DW] <= ram[b][mem_rd_addr[b*AW +: AW]];
      end
      if (mem_wr_en[b]) ram[b][mem_wr_addr[b*AW +: AW]] <= mem_wr_data[b*DW +: DW];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    acc_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic acc(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic ini,
                     input logic [NB*DW-1:0] d);
    acc_valid = 1'b1; acc_addr = a; acc_mask = m; acc_init = ini; acc_data = d;
    #1;
    chk("acc_ready", 64'(acc_ready), 64'd1);
    chk("rd_en", 64'(mem_rd_en), 64'(m));
    chk("rd_addr", 64'(mem_rd_addr[(NB-1)*AW +: AW]), 64'(a));
    for (int l = 0; l < NB; l++)
      if (m[l]) ref_mem[a][l] = ini ? d[l*DW +: DW] : ref_mem[a][l] + d[l*DW +: DW];
    @(posedge clk);
    #1;
    acc_valid = 1'b0;
  endtask

  function automatic logic [NB*DW-1:0] splat(input logic [DW-1:0] v);
    logic [NB*DW-1:0] r;
    for (int l = 0; l < NB; l++) r[l*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NB*DW-1:0] rnd_row();
    logic [NB*DW-1:0] r;
    for (int l = 0; l < NB; l++) r[l*DW +: DW] = $urandom;
    return r;
  endfunction

  // mode 0: ready always, 1: ready toggles, 2: random ready
  task automatic drain(input logic [AW-1:0] base, input logic [AW:0] len, input logic clr,
                       input int mode, input logic collide);
    int got = 0;
    int cyc = 0;
    int w = 0;
    logic rdy;
    logic prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [NB*DW-1:0] prev_data = '0;
    logic [AW-1:0] row;
    drain_start = 1'b1; drain_base = base; drain_len = len; drain_clear = clr;
    if (collide) begin
      acc_valid = 1'b1; acc_addr = base; acc_mask = '1; acc_init = 1'b0; acc_data = splat(32'd1);
    end
    #1;
    chk("start_acc_ready", 64'(acc_ready), 64'd0);
    chk("start_rd_en", 64'(mem_rd_en), 64'd0);
    @(posedge clk);
    #1;
    drain_start = 1'b0;
    acc_valid = 1'b0;
    chk("busy", 64'(drain_busy), 64'd1);
    while (got < int'(len) && cyc < 3000) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      drain_ready = rdy;
      if (prev_stall) begin
        chk("stall_valid", 64'(drain_valid), 64'd1);
        chk("stall_addr", 64'(drain_addr), 64'(prev_addr));
        chk("stall_data", 64'(drain_data == prev_data), 64'd1);
      end
      chk("done_early", 64'(drain_done), 64'd0);
      if (drain_valid && rdy) begin
        row = base + AW'(got);
        chk("drain_addr", 64'(drain_addr), 64'(row));
        for (int l = 0; l < NB; l++) begin
          chk($sformatf("row%0d_lane%0d", row, l), 64'(drain_data[l*DW +: DW]), 64'(ref_mem[row][l]));
          if (clr) ref_mem[row][l] = '0;
        end
        got++;
      end
      prev_stall = drain_valid && !rdy;
      prev_addr = drain_addr;
      prev_data = drain_data;
      step();
      cyc++;
    end
    drain_ready = 1'b0;
    if (cyc >= 3000) chk("drain_timeout", 64'(got), 64'(len));
    while (!drain_done && w < 10) begin
      chk("len0_rd_en", 64'(mem_rd_en), 64'd0);
      step();
      w++;
    end
    chk("drain_done", 64'(drain_done), 64'd1);
    if (len != '0) chk("done_latency", 64'(w), 64'd0);
    chk("done_busy", 64'(drain_busy), 64'd0);
    step();
    chk("done_pulse", 64'(drain_done), 64'd0);
    chk("idle_acc_ready", 64'(acc_ready), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB*DW-1:0] d;
    logic [NB-1:0] m;
    for (int r = 0; r < 256; r++)
      for (int l = 0; l < NB; l++) ref_mem[r][l] = '0;
    rst = 1'b1; acc_valid = 1'b0; acc_addr = '0; acc_mask = '0; acc_init = 1'b0; acc_data = '0;
    drain_start = 1'b0; drain_base = '0; drain_len = '0; drain_clear = 1'b0; drain_ready = 1'b0;
    repeat (3) step();
    chk("rst_acc_ready", 64'(acc_ready), 64'd1);
    chk("rst_busy", 64'(drain_busy), 64'd0);
    chk("rst_valid", 64'(drain_valid), 64'd0);
    chk("rst_done", 64'(drain_done), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    rst = 1'b0;
    step();

    // T1: overwrite then back-to-back accumulate on the same row
    for (int l = 0; l < NB; l++) d[l*DW +: DW] = DW'(l);
    acc(8'd5, '1, 1'b1, d);
    acc(8'd5, '1, 1'b0, splat(32'd10));
    drain(8'd5, 9'd1, 1'b0, 0, 1'b0);

    // T2: four back-to-back adds, gap of one, one more add
    acc(8'd3, '1, 1'b1, splat(32'd0));
    repeat (4) acc(8'd3, '1, 1'b0, splat(32'd1));
    idle(1);
    acc(8'd3, '1, 1'b0, splat(32'd1));
    drain(8'd3, 9'd1, 1'b0, 1, 1'b0);

    // T3: masked add, observe the write stage
    acc(8'd9, '1, 1'b1, splat(32'd100));
    idle(3);
    acc(8'd9, 16'h00FF, 1'b0, splat(32'd7));
    step();
    chk("t3_wr_en", 64'(mem_wr_en), 64'h00FF);
    chk("t3_wr_addr", 64'(mem_wr_addr[AW-1:0]), 64'd9);
    chk("t3_wr_data", 64'(mem_wr_data[DW-1:0]), 64'd107);
    drain(8'd9, 9'd1, 1'b0, 0, 1'b0);

    // T4: wrap-around of the sum
    acc(8'd20, '1, 1'b1, splat(32'hFFFF_FFFF));
    acc(8'd20, '1, 1'b0, splat(32'd2));
    drain(8'd20, 9'd1, 1'b0, 0, 1'b0);

    // T5: drain across the address wrap with clearing, then confirm zeros
    acc(8'd254, '1, 1'b1, rnd_row());
    acc(8'd255, '1, 1'b1, rnd_row());
    acc(8'd0, '1, 1'b1, rnd_row());
    acc(8'd1, '1, 1'b1, rnd_row());
    drain(8'd254, 9'd4, 1'b1, 1, 1'b0);
    drain(8'd254, 9'd4, 1'b0, 0, 1'b0);
    drain(8'd77, 9'd0, 1'b0, 0, 1'b0);

    // T6: drain_start against an accumulate request while accumulates are in flight
    acc(8'd40, '1, 1'b1, rnd_row());
    acc(8'd40, '1, 1'b0, rnd_row());
    drain(8'd40, 9'd1, 1'b0, 2, 1'b1);

    // T6: reset in the middle of a stalled drain
    drain_start = 1'b1; drain_base = 8'd100; drain_len = 9'd8; drain_clear = 1'b0;
    step();
    drain_start = 1'b0;
    repeat (6) step();
    chk("mid_valid", 64'(drain_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(acc_ready), 64'd1);
    chk("mid_rst_busy", 64'(drain_busy), 64'd0);
    chk("mid_rst_valid", 64'(drain_valid), 64'd0);
    chk("mid_rst_wr_en", 64'(mem_wr_en), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Randomized accumulate bursts on a small row set, each followed by a drain
    for (int round = 0; round < 5; round++) begin
      for (int k = 0; k < 60; k++) begin
        m = ($urandom_range(0, 3) == 0) ? '1 : NB'($urandom);
        acc(AW'($urandom_range(0, 7)), m, ($urandom_range(0, 7) == 0), rnd_row());
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      drain(8'd0, 9'd8, 1'($urandom_range(0, 1)), 2, 1'b0);
    end
    drain(AW'($urandom), 9'd256, 1'b0, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
